// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus of the operand sequencer: held operands/opcode out, combinational result and flags back.
interface alu_operand_sequencer_if;
   logic [3:0] A_out;
   logic [3:0] B_out;
   logic [1:0] OP_out;
   logic [7:0] R_in;
   logic       Z_in;
   logic       N_in;
   logic       C_in;
   logic       V_in;

   modport master (
      output A_out, B_out, OP_out,
      input  R_in, Z_in, N_in, C_in, V_in
   );

   modport slave (
      input  A_out, B_out, OP_out,
      output R_in, Z_in, N_in, C_in, V_in
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A, B, OP from a shared switch bus on button strobes, then captures the ALU result and flags.
// Optional button debounce filter enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              data_in,
   input  logic                    load_btn,
   input  logic                    clear,
   alu_operand_sequencer_if.master alu,
   output logic [7:0]              R_q,
   output logic [3:0]              flags_q,
   output logic                    valid,
   output logic [2:0]              stage
);

   typedef enum logic [2:0] {
      S_A    = 3'b000,
      S_B    = 3'b001,
      S_OP   = 3'b010,
      S_EXEC = 3'b011,
      S_SHOW = 3'b100
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [1:0] op_q, op_d;
   logic [7:0] r_q, r_d;
   logic [3:0] flg_q, flg_d;
   logic       valid_q, valid_d;

   logic s1_q, s2_q, s3_q;
   logic btn_lvl;
   logic strobe;

   // Button synchronizer; the edge flop follows the (optionally filtered) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts one stage per clock.
         s1_q <= load_btn;
         s2_q <= s1_q;
         s3_q <= btn_lvl;
      end
   end

`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

   logic             db_q;
   logic [CNT_W-1:0] cnt_q;

   // Level is accepted only after it differs from db for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else if (s2_q == db_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         db_q  <= s2_q;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign btn_lvl = db_q;
`else
   logic unused_debounce;
   assign unused_debounce = ^DEBOUNCE_CYCLES;
   assign btn_lvl = s2_q;
`endif

   assign strobe = btn_lvl & ~s3_q;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here has an async reset; there is no memory array, so nothing is left uninitialised.
      if (!rst_n) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         r_q     <= '0;
         flg_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         r_q     <= r_d;
         flg_q   <= flg_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      // NOTE: hold-by-default assignments first, so no path through this block can infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      r_d     = r_q;
      flg_d   = flg_q;
      valid_d = valid_q;

      if (clear) begin
         state_d = S_A;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         r_d     = '0;
         flg_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_A: if (strobe) begin
               a_d     = data_in;
               state_d = S_B;
            end
            S_B: if (strobe) begin
               b_d     = data_in;
               state_d = S_OP;
            end
            S_OP: if (strobe) begin
               op_d    = data_in[1:0];
               state_d = S_EXEC;
            end
            S_EXEC: begin
               r_d     = alu.R_in;
               flg_d   = {alu.Z_in, alu.N_in, alu.C_in, alu.V_in};
               valid_d = 1'b1;
               state_d = S_SHOW;
            end
            S_SHOW: if (strobe) begin
               // Result registers stay on display until the next capture.
               a_d     = data_in;
               valid_d = 1'b0;
               state_d = S_B;
            end
            default: state_d = S_A;
         endcase
      end
   end

   assign alu.A_out  = a_q;
   assign alu.B_out  = b_q;
   assign alu.OP_out = op_q;
   assign R_q        = r_q;
   assign flags_q    = flg_q;
   assign valid      = valid_q;
   assign stage      = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_operand_sequencer;

`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int EXTRA = 16;
   localparam int HOLD = 20;
   localparam int SETTLE = 24;
`else
   localparam int EXTRA = 0;
   localparam int HOLD = 2;
   localparam int SETTLE = 4;
`endif
   localparam int EXP_LAT = 3 + EXTRA;

   typedef struct packed {
      logic [7:0] r;
      logic [3:0] f;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] data_in = '0;
   logic       load_btn = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] R_q;
   logic [3:0] flags_q;
   logic       valid;
   logic [2:0] stage;

   logic       ovr_en = 1'b0;
   logic [7:0] ovr_r = '0;
   logic [3:0] ovr_f = '0;
   res_t       model_res;

   int   checks = 0;
   int   failures = 0;
   res_t sb_q[$];

   alu_operand_sequencer_if alu_if ();

   alu_operand_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_btn(load_btn), .clear(clear),
      .alu(alu_if.master), .R_q(R_q), .flags_q(flags_q), .valid(valid), .stage(stage)
   );

   always #5 clk = ~clk;

   function automatic res_t alu_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      res_t       res;
      logic [4:0] d;
      logic       c, v;
      c = 1'b0;
      v = 1'b0;
      d = {1'b0, a} - {1'b0, b};
      case (op)
         2'b00: res.r = {4'b0, a} * {4'b0, b};
         2'b01: begin
            res.r = {{4{d[3]}}, d[3:0]};
            c = d[4];
            v = (a[3] != b[3]) && (d[3] != a[3]);
         end
         2'b10: res.r = {4'b0, a & b};
         default: res.r = {4'b0, a ^ b};
      endcase
      res.f = {res.r == 8'h00, res.r[7], c, v};
      return res;
   endfunction

   assign model_res     = alu_model(alu_if.A_out, alu_if.B_out, alu_if.OP_out);
   assign alu_if.R_in   = ovr_en ? ovr_r : model_res.r;
   assign {alu_if.Z_in, alu_if.N_in, alu_if.C_in, alu_if.V_in} = ovr_en ? ovr_f : model_res.f;

   task automatic press(input logic [3:0] d);
      @(negedge clk);
      data_in  = d;
      load_btn = 1'b1;
      repeat (HOLD) @(negedge clk);
      load_btn = 1'b0;
      repeat (SETTLE) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int   n;
      res_t exp;
      n = 0;
      while (!valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!valid) begin
         failures++;
         $display("FAIL %s_timeout: valid never rose within %0d cycles", name, n);
      end else if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s_sb_empty: valid high with no expected result queued", name);
      end else begin
         exp = sb_q.pop_front();
         if ({R_q, flags_q} !== exp) begin
            failures++;
            $display("FAIL %s_result: R_q=%h flags=%b expected R_q=%h flags=%b", name, R_q, flags_q, exp.r, exp.f);
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({alu_if.A_out, alu_if.B_out, alu_if.OP_out, R_q, flags_q, valid, stage} !== '0) begin
         failures++;
         $display("FAIL reset_state: A=%h B=%h OP=%b R=%h F=%b v=%b st=%b expected all zero",
                  alu_if.A_out, alu_if.B_out, alu_if.OP_out, R_q, flags_q, valid, stage);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      int n;
      @(negedge clk);
      data_in  = 4'h6;
      load_btn = 1'b1;
      n = 0;
      while (stage == 3'b000 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n !== EXP_LAT) begin
         failures++;
         $display("FAIL load_latency: got %0d edges expected %0d", n, EXP_LAT);
      end
      checks++;
      if (alu_if.A_out !== 4'h6 || stage !== 3'b001) begin
         failures++;
         $display("FAIL latency_load: A=%h st=%b expected A=6 st=001", alu_if.A_out, stage);
      end
      @(negedge clk);
      load_btn = 1'b0;
      repeat (SETTLE) @(negedge clk);
      do_clear();
   endtask

   task automatic test_basic();
      press(4'h3);
      press(4'h5);
      sb_q.push_back(alu_model(4'h3, 4'h5, 2'b00));
      press(4'h0);
      checks++;
      if (alu_if.A_out !== 4'h3 || alu_if.B_out !== 4'h5 || alu_if.OP_out !== 2'b00) begin
         failures++;
         $display("FAIL basic_operands: A=%h B=%h OP=%b expected 3 5 00", alu_if.A_out, alu_if.B_out, alu_if.OP_out);
      end
      wait_valid("basic");
      checks++;
      if (R_q !== 8'h0F || flags_q[3:2] !== 2'b00 || valid !== 1'b1 || stage !== 3'b100) begin
         failures++;
         $display("FAIL basic_show: R=%h ZN=%b v=%b st=%b expected 0f 00 1 100", R_q, flags_q[3:2], valid, stage);
      end
   endtask

   task automatic test_override();
      ovr_en = 1'b1;
      ovr_r  = 8'hA5;
      ovr_f  = 4'b1010;
      press(4'h1);
      press(4'h2);
      sb_q.push_back('{r: 8'hA5, f: 4'b1010});
      press(4'h0);
      wait_valid("override");
      ovr_r = 8'h3C;
      ovr_f = 4'b0101;
      repeat (5) @(negedge clk);
      checks++;
      if (R_q !== 8'hA5 || flags_q !== 4'b1010) begin
         failures++;
         $display("FAIL override_hold: R=%h F=%b expected a5 1010", R_q, flags_q);
      end
      ovr_en = 1'b0;
   endtask

   task automatic test_show();
      press(4'h1);
      press(4'h2);
      sb_q.push_back(alu_model(4'h1, 4'h2, 2'b11));
      press(4'h3);
      wait_valid("show_xor");
      press(4'h9);
      checks++;
      if (alu_if.A_out !== 4'h9 || valid !== 1'b0 || stage !== 3'b001 || R_q !== 8'h03 || alu_if.B_out !== 4'h2) begin
         failures++;
         $display("FAIL show_restart: A=%h v=%b st=%b R=%h B=%h expected 9 0 001 03 2",
                  alu_if.A_out, valid, stage, R_q, alu_if.B_out);
      end
   endtask

   task automatic test_clear();
      press(4'h2);
      checks++;
      if (stage !== 3'b010) begin
         failures++;
         $display("FAIL clear_pre: st=%b expected 010", stage);
      end
      @(negedge clk);
      clear    = 1'b1;
      data_in  = 4'h1;
      load_btn = 1'b1;
      repeat (HOLD) @(negedge clk);
      load_btn = 1'b0;
      repeat (SETTLE) @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      checks++;
      if ({alu_if.A_out, alu_if.B_out, alu_if.OP_out, R_q, flags_q, valid, stage} !== '0) begin
         failures++;
         $display("FAIL clear_priority: A=%h B=%h OP=%b R=%h F=%b v=%b st=%b expected all zero",
                  alu_if.A_out, alu_if.B_out, alu_if.OP_out, R_q, flags_q, valid, stage);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      data_in  = 4'h7;
      load_btn = 1'b1;
      repeat (50) @(negedge clk);
      checks++;
      if (alu_if.A_out !== 4'h7 || stage !== 3'b001 || alu_if.B_out !== 4'h0) begin
         failures++;
         $display("FAIL hold_one_load: A=%h st=%b B=%h expected 7 001 0", alu_if.A_out, stage, alu_if.B_out);
      end
      load_btn = 1'b0;
      repeat (SETTLE) @(negedge clk);
      checks++;
      if (stage !== 3'b001) begin
         failures++;
         $display("FAIL hold_release: st=%b expected 001", stage);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({alu_if.A_out, alu_if.B_out, alu_if.OP_out, R_q, flags_q, valid, stage} !== '0) begin
         failures++;
         $display("FAIL async_reset: A=%h st=%b v=%b expected all zero before clock edge", alu_if.A_out, stage, valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef ALU_SEQ_DEBOUNCE_EN
   task automatic test_debounce();
      @(negedge clk);
      data_in  = 4'hC;
      load_btn = 1'b1;
      repeat (10) @(negedge clk);
      load_btn = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (stage !== 3'b000 || alu_if.A_out !== 4'h0) begin
         failures++;
         $display("FAIL debounce_short: st=%b A=%h expected 000 0", stage, alu_if.A_out);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
`ifdef ALU_SEQ_DEBOUNCE_EN
      test_debounce();
`endif
      test_latency();
      test_basic();
      test_override();
      test_show();
      test_clear();
      test_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Sequential front end for the 4-bit ALU: collects A, B and OP one at a time from a shared 4-bit input bus, advancing on a push-button strobe.
Drives the held operands and opcode to the combinational ALU.
Captures the ALU result and flags into output registers one cycle after the opcode is loaded, and flags them valid for display.
Sits directly upstream of the ALU (feeds A/B/OP) and also registers its outputs (R, Z, N, C, V).

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level change is accepted (used only with ALU_SEQ_DEBOUNCE_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  4  operand/opcode entry bus (switches); OP uses bits [1:0], bits [3:2] ignored for OP
load_btn  input  1  asynchronous load button, active-high level
clear  input  1  synchronous clear, active-high
A_out  output  4  held operand A, to ALU
B_out  output  4  held operand B, to ALU
OP_out  output  2  held opcode, to ALU (00 mult, 01 sub, 10 AND, 11 XOR)
R_in  input  8  ALU result
Z_in, N_in, C_in, V_in  input  1 each  ALU flags
R_q  output  8  captured result
flags_q  output  4  captured flags {Z,N,C,V}
valid  output  1  R_q/flags_q correspond to the current A/B/OP
stage  output  3  current state encoding, for LEDs

Behaviour:
- Reset (rst_n low, async): all registers 0.
  - A_out=0, B_out=0, OP_out=00, R_q=0, flags_q=0, valid=0, stage=S_A.
  - Synchronizer and edge flops = 0.
- Button path: 2-flop synchronizer s1->s2, then edge flop s3.
  - strobe = s2 & ~s3.
  - Rising edge of load_btn sampled at edge t0 gives strobe high between t1 and t2; the register update occurs at edge t2.
  - Holding load_btn high yields exactly one strobe; a new strobe needs load_btn low for at least one sampled cycle.
- States (stage encoding): S_A=000, S_B=001, S_OP=010, S_EXEC=011, S_SHOW=100. Unused encodings go to S_A.
  - S_A: on strobe, A_out<=data_in, go S_B.
  - S_B: on strobe, B_out<=data_in, go S_OP.
  - S_OP: on strobe, OP_out<=data_in[1:0], go S_EXEC.
  - S_EXEC: exactly one cycle, unconditional. R_q<=R_in, flags_q<={Z_in,N_in,C_in,V_in}, valid<=1, go S_SHOW.
  - S_SHOW: hold all outputs. On strobe: A_out<=data_in, valid<=0, go S_B. R_q/flags_q keep their old values until the next S_EXEC.
- Latency: OP strobe at edge t2 -> capture at t3 -> valid high after t3. The ALU is combinational, so R_in is settled during the S_EXEC cycle.
- clear (synchronous) has priority over strobe in every state.
  - Next state S_A; A_out, B_out, OP_out, R_q, flags_q all 0; valid=0.
  - The synchronizer is not cleared.
- No strobe in a state: all registers hold.
- rst_n asserted mid-sequence: immediate return to reset values; the partially entered operands are discarded.
- Outputs A_out/B_out/OP_out change only on their own load, on clear, or on reset; never glitch between loads.

Optional Feature:
ALU_SEQ_DEBOUNCE_EN
- Defined: a debounce filter sits between s2 and the edge detector.
  - Debounced level db, counter cnt of width $clog2(DEBOUNCE_CYCLES)+1.
  - When s2==db: cnt<=0.
  - Otherwise cnt increments; when cnt==DEBOUNCE_CYCLES-1: db<=s2, cnt<=0.
  - s3 samples db; strobe = db & ~s3.
  - Pulses or glitches shorter than DEBOUNCE_CYCLES cycles produce no strobe.
  - Adds DEBOUNCE_CYCLES cycles of latency. db and cnt reset to 0.
- Undefined: no filter; timing as in Behaviour; DEBOUNCE_CYCLES unused.

Test Plan:
- Bench ALU connected; enter A=3, B=5, OP=00 -> A_out=3, B_out=5, OP_out=00; after S_EXEC, R_q=0x0F, flags_q[3]=0, flags_q[2]=0, valid=1, stage=100.
- Bench drives R_in=0xA5, {Z,N,C,V}=1010 during S_EXEC -> R_q=0xA5, flags_q=1010. Change R_in afterwards -> R_q unchanged.
- load_btn held high 50 cycles in S_A with data_in=7 -> one load only: A_out=7, stage=001. B_out unchanged.
- clear asserted in S_OP together with a strobe -> stage=000, all outputs 0, valid=0. rst_n pulsed low in S_B -> same values immediately, without waiting for clk.
- From S_SHOW, strobe with data_in=9 -> A_out=9, valid=0, stage=001, R_q retains its previous value.
- With ALU_SEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - 10-cycle button pulse -> no state change.
  - 20-cycle pulse -> exactly one load, 16 cycles later than in the non-debounced build.
